// File: rtl/rf80386_ibundle_fetch.sv
// rf80386 instruction-fetch front end. A small fully-associative line
// buffer turns the linear fetch address into a byte-aligned 16-byte
// instruction bundle. Misses and next-line prefetches are refilled one
// line at a time.
//
// Memory handshake: mreq_o/madr_o are raised together and held stable
// until the cycle in which mack_i is high. mdat_i is taken in that same
// cycle, and mreq_o drops on the following edge. Only one request is
// ever outstanding, and an ack seen while no request is open is ignored.
module rf80386_ibundle_fetch #(
  parameter int NENT     = 4,
  parameter bit PREFETCH = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  csip,
  input  logic         flush_i,
  output logic [127:0] ibundle,
  output logic         ihit,
  output logic         mreq_o,
  output logic [27:0]  madr_o,
  input  logic         mack_i,
  input  logic [127:0] mdat_i
);

  localparam int RW = (NENT > 1) ? $clog2(NENT) : 1;

  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e             state_q, state_d;
  logic [NENT-1:0]    valid_q, valid_d;
  logic [27:0]        tag_q [NENT];
  logic [27:0]        tag_d [NENT];
  logic [127:0]       data_q [NENT];
  logic [RW-1:0]      rr_q, rr_d;
  logic               drop_q, drop_d;
  logic               mreq_q, mreq_d;
  logic [27:0]        madr_q, madr_d;

  logic [27:0]        l0, l1, l2;
  logic [NENT-1:0]    hit0, hit1, hit2;
  logic               hit_l0, hit_l1, hit_l2;
  logic [127:0]       line0, line1;
  logic [255:0]       pair_sh;
  logic [RW-1:0]      vict;
  logic               vict_found;
  logic               we;

  // Entry index k slots after the round-robin pointer, wrapping.
  function automatic logic [RW-1:0] ring(input logic [RW-1:0] rr, input int k);
    return RW'((int'(rr) + k) % NENT);
  endfunction

  assign mreq_o = mreq_q;
  assign madr_o = madr_q;

  // Tag match for the current, next and next-next line, and bundle assembly.
  always_comb begin
    l0    = csip[31:4];
    l1    = l0 + 28'd1;
    l2    = l0 + 28'd2;
    line0 = '0;
    line1 = '0;
    for (int i = 0; i < NENT; i++) begin
      hit0[i] = valid_q[i] && (tag_q[i] == l0);
      hit1[i] = valid_q[i] && (tag_q[i] == l1);
      hit2[i] = valid_q[i] && (tag_q[i] == l2);
      if (hit0[i]) line0 = line0 | data_q[i];
      if (hit1[i]) line1 = line1 | data_q[i];
    end
    hit_l0  = |hit0;
    hit_l1  = |hit1;
    hit_l2  = |hit2;
    pair_sh = {line1, line0} >> {csip[3:0], 3'b000};
    ihit    = hit_l0 && hit_l1;
    ibundle = ihit ? pair_sh[127:0] : '0;
  end

  // Victim choice: first free slot from rr, else first slot from rr that
  // holds neither the current line nor the one after it.
  always_comb begin
    vict       = '0;
    vict_found = 1'b0;
    for (int k = 0; k < NENT; k++) begin
      if (!vict_found && !valid_q[ring(rr_q, k)]) begin
        vict       = ring(rr_q, k);
        vict_found = 1'b1;
      end
    end
    for (int k = 0; k < NENT; k++) begin
      if (!vict_found && (tag_q[ring(rr_q, k)] != l0) && (tag_q[ring(rr_q, k)] != l1)) begin
        vict       = ring(rr_q, k);
        vict_found = 1'b1;
      end
    end
  end

  // Refill FSM: pick the line to request in IDLE, install or drop on ack.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    rr_d    = rr_q;
    drop_d  = drop_q;
    mreq_d  = mreq_q;
    madr_d  = madr_q;
    we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          valid_d = '0;
          rr_d    = '0;
        end else if (!hit_l0) begin
          madr_d  = l0;
          mreq_d  = 1'b1;
          state_d = S_REQ;
        end else if (!hit_l1) begin
          madr_d  = l1;
          mreq_d  = 1'b1;
          state_d = S_REQ;
        end else if (PREFETCH && !hit_l2) begin
          madr_d  = l2;
          mreq_d  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mack_i) begin
          mreq_d  = 1'b0;
          drop_d  = 1'b0;
          state_d = S_IDLE;
          if (flush_i) begin
            valid_d = '0;
            rr_d    = '0;
          end else if (!drop_q) begin
            valid_d[vict] = 1'b1;
            tag_d[vict]   = madr_q;
            we            = 1'b1;
            rr_d          = ring(vict, 1);
          end
        end else if (flush_i) begin
          // Keep the request open; the data that comes back is stale.
          valid_d = '0;
          rr_d    = '0;
          drop_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      rr_q    <= '0;
      drop_q  <= 1'b0;
      mreq_q  <= 1'b0;
      madr_q  <= '0;
      for (int i = 0; i < NENT; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
      mreq_q  <= mreq_d;
      madr_q  <= madr_d;
      for (int i = 0; i < NENT; i++) tag_q[i] <= tag_d[i];
    end
  end

  // Line data storage; never reset, only written on an accepted fill.
  always_ff @(posedge clk_i) begin
    if (we) data_q[vict] <= mdat_i;
  end

endmodule

// File: tb/tb_rf80386_ibundle_fetch.sv
// Bench for rf80386_ibundle_fetch: directed scenarios followed by random
// fetch traffic, compared every cycle against a line-residency model.
module tb_rf80386_ibundle_fetch;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  csip = '0;
  logic         flush_i = 1'b0;
  logic [127:0] ibundle;
  logic         ihit;
  logic         mreq_o;
  logic [27:0]  madr_o;
  logic         mack_i = 1'b0;
  logic [127:0] mdat_i = '0;

  int checks = 0;
  int errors = 0;

  // Reference model: which lines are resident, and the open request.
  bit          mv [4];
  logic [27:0] mt [4];
  int          mrr;
  bit          m_req;
  bit          m_drop;
  logic [27:0] m_adr;
  int          m_wait;
  int          ack_dly;

  rf80386_ibundle_fetch #(.NENT(4), .PREFETCH(1'b1)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .csip    (csip),
    .flush_i (flush_i),
    .ibundle (ibundle),
    .ihit    (ihit),
    .mreq_o  (mreq_o),
    .madr_o  (madr_o),
    .mack_i  (mack_i),
    .mdat_i  (mdat_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory contents: low address byte salted with upper line bits.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[31:24] ^ a[23:16];
  endfunction

  function automatic logic [127:0] line_data(input logic [27:0] ln);
    logic [127:0] d;
    for (int j = 0; j < 16; j++) d[j*8 +: 8] = mem_byte({ln, 4'(j)});
    return d;
  endfunction

  function automatic logic [127:0] exp_bundle(input logic [31:0] a);
    logic [127:0] b;
    for (int j = 0; j < 16; j++) b[j*8 +: 8] = mem_byte(a + 32'(j));
    return b;
  endfunction

  function automatic bit resident(input logic [27:0] ln);
    for (int i = 0; i < 4; i++) if (mv[i] && mt[i] == ln) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int victim(input logic [27:0] p0, input logic [27:0] p1);
    for (int k = 0; k < 4; k++) if (!mv[(mrr + k) % 4]) return (mrr + k) % 4;
    for (int k = 0; k < 4; k++)
      if (mt[(mrr + k) % 4] != p0 && mt[(mrr + k) % 4] != p1) return (mrr + k) % 4;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    mrr = 0;
  endtask

  task automatic model_reset();
    model_clear();
    for (int i = 0; i < 4; i++) mt[i] = '0;
    m_req  = 1'b0;
    m_drop = 1'b0;
    m_adr  = '0;
    m_wait = 0;
  endtask

  task automatic model_update(input logic [31:0] a, input bit fl, input bit ack);
    logic [27:0] p0, p1, p2;
    int v;
    p0 = a[31:4];
    p1 = p0 + 28'd1;
    p2 = p0 + 28'd2;
    if (m_req) begin
      if (ack) begin
        if (fl) model_clear();
        else if (!m_drop) begin
          v = victim(p0, p1);
          mv[v] = 1'b1;
          mt[v] = m_adr;
          mrr = (v + 1) % 4;
        end
        m_drop = 1'b0;
        m_req  = 1'b0;
      end else begin
        if (fl) begin
          model_clear();
          m_drop = 1'b1;
        end
        m_wait++;
      end
    end else if (fl) begin
      model_clear();
    end else if (!resident(p0) || !resident(p1) || !resident(p2)) begin
      m_adr  = !resident(p0) ? p0 : (!resident(p1) ? p1 : p2);
      m_req  = 1'b1;
      m_wait = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit eh;
    eh = resident(csip[31:4]) && resident(csip[31:4] + 28'd1);
    chk("ihit", 128'(ihit), 128'(eh));
    chk("ibundle", ibundle, eh ? exp_bundle(csip) : 128'h0);
    chk("mreq_o", 128'(mreq_o), 128'(m_req));
    if (m_req) chk("madr_o", 128'(madr_o), 128'(m_adr));
  endtask

  // One clock: drive at the falling edge, check, then advance the model.
  task automatic step(input logic [31:0] a, input bit fl, input bit force_ack);
    bit ack;
    @(negedge clk_i);
    ack     = force_ack || (m_req && m_wait == ack_dly);
    csip    = a;
    flush_i = fl;
    mack_i  = ack;
    mdat_i  = m_req ? line_data(m_adr) : {$urandom, $urandom, $urandom, $urandom};
    #1;
    check_outputs();
    @(posedge clk_i);
    model_update(a, fl, ack);
  endtask

  task automatic run(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) step(a, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    model_reset();
    ack_dly = 2;

    // Reset values.
    repeat (2) @(negedge clk_i);
    chk("rst_mreq", 128'(mreq_o), 128'h0);
    chk("rst_madr", 128'(madr_o), 128'h0);
    chk("rst_ihit", 128'(ihit), 128'h0);
    chk("rst_ibundle", ibundle, 128'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;

    // Cold start at 0x1000: fills 0x100, 0x101, 0x102 in order.
    run(32'h0000_1000, 14);
    chk("cold_bundle", ibundle, line_data(28'h100));
    chk("cold_ihit", 128'(ihit), 128'h1);

    // Unaligned fetch spanning two lines.
    run(32'h0000_100D, 2);
    chk("unal_lo", 128'(ibundle[23:0]), 128'h0F0E0D);
    chk("unal_hi", 128'(ibundle[127:120]), 128'h1C);

    // Address wrap at the top of the linear space.
    ack_dly = 1;
    run(32'hFFFF_FFF8, 14);
    chk("wrap_b8", 128'(ibundle[71:64]), 128'h00);

    // Flush while a request is open; the returning line must be dropped.
    ack_dly = 5;
    step(32'h0000_3000, 1'b0, 1'b0);
    step(32'h0000_3000, 1'b0, 1'b0);
    step(32'h0000_3000, 1'b1, 1'b0);
    run(32'h0000_3000, 20);

    // Flush coincident with an ack.
    ack_dly = 3;
    step(32'h0000_3800, 1'b1, 1'b0);
    step(32'h0000_3800, 1'b0, 1'b0);
    step(32'h0000_3800, 1'b0, 1'b0);
    step(32'h0000_3800, 1'b1, 1'b1);
    run(32'h0000_3800, 12);

    // Capacity: fill, then walk sequentially over six lines.
    ack_dly = 0;
    step(32'h0000_4000, 1'b1, 1'b0);
    run(32'h0000_4000, 10);
    for (int l = 0; l < 6; l++)
      for (int i = 0; i < 8; i++)
        step(32'h0000_4000 + 32'(l * 16) + 32'($urandom_range(0, 15)), 1'b0, 1'b0);

    // Reset in the middle of a request, then a stray ack.
    ack_dly = 3;
    step(32'h0000_5000, 1'b0, 1'b0);
    step(32'h0000_5000, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("midrst_mreq", 128'(mreq_o), 128'h0);
    chk("midrst_ihit", 128'(ihit), 128'h0);
    model_reset();
    csip   = 32'h0;
    mack_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    step(32'h0000_0000, 1'b0, 1'b1);
    ack_dly = 1;
    run(32'h0000_0000, 12);

    // Random fetch traffic with random ack latency and occasional flushes.
    a = 32'h0000_6000;
    for (int i = 0; i < 500; i++) begin
      if (!m_req) ack_dly = $urandom_range(0, 3);
      case ($urandom_range(0, 9))
        0: a = 32'h0000_6000 + 32'($urandom_range(0, 127));
        1, 2: a = a + 32'($urandom_range(1, 20));
        default: ;
      endcase
      step(a, ($urandom_range(0, 39) == 0), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
